// File: rtl/multdiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // ALU opcodes steered to this unit by execute-stage decode
  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdState_e;

endpackage

// File: rtl/multdiv_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Execute-stage side: issues operands and start pulses
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Unit side
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   remIn,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividendBit,
  output logic [WIDTH:0]   remOut,
  output logic             quotBit
);

  // One extra bit of headroom so the compare never wraps, even for a
  // divisor magnitude of 2^(WIDTH-1).
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divExt;

  assign shifted = {remIn, dividendBit};
  assign divExt  = {2'b00, divisor};
  assign quotBit = (shifted >= divExt);
  // The restored remainder is always below the divisor, so WIDTH+1 bits hold it.
  assign remOut  = quotBit ? (WIDTH+1)'(shifted - divExt) : (WIDTH+1)'(shifted);

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// Start sampled at E0, one bit per edge on E1..E32, outputs registered at E33.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic      clock,
  input  logic      reset_n,
  multdiv_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  mdState_e stateReg, stateNext;

  logic [CNT_W-1:0]   cntReg;
  logic [2*WIDTH:0]   prodReg;       // {upper, multiplier, booth guard bit}
  logic [2*WIDTH:0]   prodNext;
  logic [WIDTH-1:0]   mcandReg;      // multiplicand for MUL, |B| for DIV
  logic [WIDTH-1:0]   quoReg;        // |A| shifting out, quotient shifting in
  logic [WIDTH-1:0]   quoNext;
  logic [WIDTH:0]     remReg;
  logic [WIDTH:0]     remNext;
  logic               negReg;
  logic               divZeroReg;
  logic               divOvfReg;
  logic [WIDTH-1:0]   resultReg, resultNext;
  logic               excReg, excNext;
  logic               rdyReg;

  logic               startMul, startDiv, doStep, finalize;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     boothUpper, boothM, boothSum;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     productHigh;
  logic               stepQuotBit;

  // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1) unchanged.
  assign magA = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign magB = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next state and per-cycle datapath controls; starts only accepted when idle or done
  always_comb begin
    stateNext = stateReg;
    startMul  = 1'b0;
    startDiv  = 1'b0;
    doStep    = 1'b0;
    finalize  = 1'b0;
    case (stateReg)
      IDLE, DONE: begin
        if (bus.ctrl_MULT) begin
          startMul  = 1'b1;
          stateNext = MUL;
        end else if (bus.ctrl_DIV) begin
          startDiv  = 1'b1;
          stateNext = DIV;
        end else begin
          stateNext = IDLE;
        end
      end
      MUL, DIV: begin
        if (cntReg == LAST_CNT) begin
          finalize  = 1'b1;
          stateNext = DONE;
        end else begin
          doStep = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Booth step: sign-extended accumulator so subtracting the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  assign boothUpper = {prodReg[2*WIDTH], prodReg[2*WIDTH:WIDTH+1]};
  assign boothM     = {mcandReg[WIDTH-1], mcandReg};

  // Booth recoding of the current multiplier bit pair
  always_comb begin
    boothSum = boothUpper;
    case (prodReg[1:0])
      2'b01:   boothSum = boothUpper + boothM;
      2'b10:   boothSum = boothUpper - boothM;
      default: boothSum = boothUpper;
    endcase
  end

  assign prodNext = {boothSum, prodReg[WIDTH:1]};

  div_step #(.WIDTH(WIDTH)) u_divStep (
    .remIn       (remReg),
    .divisor     (mcandReg),
    .dividendBit (quoReg[WIDTH-1]),
    .remOut      (remNext),
    .quotBit     (stepQuotBit)
  );

  assign quoNext     = {quoReg[WIDTH-2:0], stepQuotBit};
  assign product     = prodReg[2*WIDTH:1];
  assign productHigh = product[2*WIDTH-1:WIDTH-1];

  // Final result/exception selection, only captured on the finalize edge
  always_comb begin
    resultNext = resultReg;
    excNext    = excReg;
    if (stateReg == MUL) begin
      resultNext = product[WIDTH-1:0];
      excNext    = !((&productHigh) || !(|productHigh));
    end else if (divZeroReg) begin
      resultNext = '0;
      excNext    = 1'b1;
    end else if (divOvfReg) begin
      resultNext = MIN_NEG;
      excNext    = 1'b1;
    end else begin
      // Negating a zero quotient leaves +0, so no special case is needed.
      resultNext = negReg ? -quoReg : quoReg;
      excNext    = 1'b0;
    end
  end

  // Operand capture, iteration and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cntReg     <= '0;
      prodReg    <= '0;
      mcandReg   <= '0;
      quoReg     <= '0;
      remReg     <= '0;
      negReg     <= 1'b0;
      divZeroReg <= 1'b0;
      divOvfReg  <= 1'b0;
      resultReg  <= '0;
      excReg     <= 1'b0;
      rdyReg     <= 1'b0;
    end else begin
      rdyReg <= finalize;
      if (startMul) begin
        cntReg   <= '0;
        mcandReg <= bus.data_operandA;
        prodReg  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      end else if (startDiv) begin
        cntReg     <= '0;
        mcandReg   <= magB;
        quoReg     <= magA;
        remReg     <= '0;
        negReg     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        divZeroReg <= (bus.data_operandB == '0);
        divOvfReg  <= (bus.data_operandA == MIN_NEG) && (bus.data_operandB == ALL_ONES);
      end else if (doStep) begin
        cntReg <= cntReg + 1'b1;
        if (stateReg == MUL) begin
          prodReg <= prodNext;
        end else begin
          remReg <= remNext;
          quoReg <= quoNext;
        end
      end
      if (finalize) begin
        resultReg <= resultNext;
        excReg    <= excNext;
      end
    end
  end

  assign bus.data_result    = resultReg;
  assign bus.data_exception = excReg;
  assign bus.data_resultRDY = rdyReg;
  assign bus.busy           = (stateReg == MUL) || (stateReg == DIV);

endmodule
